// File: rtl/prm_edge_mask_accum.sv
`default_nettype none
// ============================================================================
//  Module   : prm_edge_mask_accum
//  Purpose  : Streams obstacle codes to a combinational array of PRM edge
//             checkers and sticky-ORs the returned per-edge masks into a
//             blocked-edge bitmap over one frame. At end of frame the bitmap
//             is drained as OUT_W-bit words to the path-search stage.
//  Ports    : CLK, RST            clock / synchronous active-high reset
//             obs_valid/ready     obstacle code handshake (+ obs_code, obs_last)
//             chk_code            code broadcast to the checker array
//             edge_mask_in        checker outputs for chk_code (same cycle)
//             frame_abort         discard current frame
//             out_valid/ready     bitmap word handshake (+ out_data, out_idx,
//                                 out_last)
//             frame_done          pulse the cycle after the last word is taken
//             blocked_cnt         popcount of the bitmap (optional)
//  Options  : define PRM_BLOCKED_CNT_EN to add the blocked_cnt output.
//  Revision : 1.0  initial release
// ============================================================================
module prm_edge_mask_accum #(
    parameter  int NUM_EDGES = 1024,
    parameter  int OUT_W     = 32,
    parameter  int CODE_W    = 15,
    localparam int NUM_WORDS = NUM_EDGES / OUT_W,
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int CNT_W     = $clog2(NUM_EDGES + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic [CODE_W-1:0]    obs_code,
    input  logic                 obs_last,
    output logic [CODE_W-1:0]    chk_code,
    input  logic [NUM_EDGES-1:0] edge_mask_in,
    input  logic                 frame_abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
`ifdef PRM_BLOCKED_CNT_EN
    output logic [CNT_W-1:0]     blocked_cnt,
`endif
    output logic                 frame_done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [NUM_EDGES-1:0] r_accum;
    logic [NUM_EDGES-1:0] w_accum_next;
    logic [IDX_W-1:0]     r_k;
    logic                 r_frame_done;
    logic                 w_accept;
    logic                 w_word_take;
    logic                 w_last_word;
    logic                 w_frame_end;
    logic [OUT_W-1:0]     w_words [NUM_WORDS];

    // Checkers are purely combinational: the code goes straight out and the
    // resulting mask comes back in the same cycle.
    assign chk_code = obs_code;

    assign w_accept    = obs_valid & obs_ready;
    assign w_last_word = (r_k == c_LAST_IDX);
    assign w_word_take = out_valid & out_ready;
    assign w_frame_end = w_word_take & w_last_word;

    // The first accept of a frame loads rather than ORs, so the previous
    // frame's bitmap never leaks into the next one.
    always_comb begin
        w_accum_next = r_accum;
        if (w_accept) begin
            if (r_state == c_ST_IDLE) begin
                w_accum_next = edge_mask_in;
            end else begin
                w_accum_next = r_accum | edge_mask_in;
            end
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        if (frame_abort) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        w_state_next = obs_last ? c_ST_DRAIN : c_ST_ACCUM;
                    end
                end
                c_ST_ACCUM: begin
                    if (w_accept && obs_last) begin
                        w_state_next = c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (w_frame_end) begin
                        w_state_next = c_ST_IDLE;
                    end
                end
                default: w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        obs_ready = 1'b1;
        out_valid = 1'b0;
        case (r_state)
            c_ST_DRAIN: begin
                obs_ready = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                obs_ready = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    // Word k is selected from the held bitmap, so data/idx/last stay stable
    // while the consumer stalls.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
        assign w_words[gi] = r_accum[gi*OUT_W +: OUT_W];
    end

    assign out_data   = w_words[r_k];
    assign out_idx    = r_k;
    assign out_last   = out_valid & w_last_word;
    assign frame_done = r_frame_done;

    // ------------------------------------------------------ datapath regs
    always_ff @(posedge CLK) begin
        if (RST || frame_abort) begin
            r_accum      <= '0;
            r_k          <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_accum      <= w_accum_next;
            r_frame_done <= w_frame_end;
            if (w_word_take) begin
                r_k <= w_last_word ? '0 : r_k + 1'b1;
            end
        end
    end

`ifdef PRM_BLOCKED_CNT_EN
    // Popcount of the final OR result, captured on the transition into DRAIN
    // and held until the next frame reaches DRAIN.
    logic [CNT_W-1:0] r_blocked_cnt;
    logic [CNT_W-1:0] w_popcnt;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_EDGES; i++) begin
            w_popcnt = w_popcnt + CNT_W'(w_accum_next[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || frame_abort) begin
            r_blocked_cnt <= '0;
        end else if (w_accept && obs_last) begin
            r_blocked_cnt <= w_popcnt;
        end
    end

    assign blocked_cnt = r_blocked_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prm_edge_mask_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prm_edge_mask_accum
//  Purpose  : Directed self-checking bench for prm_edge_mask_accum with
//             NUM_EDGES=64, OUT_W=32.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prm_edge_mask_accum;

    localparam int NUM_EDGES = 64;
    localparam int OUT_W     = 32;
    localparam int CODE_W    = 15;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              obs_valid = 1'b0;
    logic              obs_ready;
    logic [CODE_W-1:0] obs_code = '0;
    logic              obs_last = 1'b0;
    logic [CODE_W-1:0] chk_code;
    logic [63:0]       edge_mask_in = '0;
    logic              frame_abort = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;
    logic [0:0]        out_idx;
    logic              out_last;
    logic              frame_done;
`ifdef PRM_BLOCKED_CNT_EN
    logic [6:0]        blocked_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    prm_edge_mask_accum #(
        .NUM_EDGES(NUM_EDGES),
        .OUT_W    (OUT_W),
        .CODE_W   (CODE_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .obs_valid   (obs_valid),
        .obs_ready   (obs_ready),
        .obs_code    (obs_code),
        .obs_last    (obs_last),
        .chk_code    (chk_code),
        .edge_mask_in(edge_mask_in),
        .frame_abort (frame_abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
`ifdef PRM_BLOCKED_CNT_EN
        .blocked_cnt (blocked_cnt),
`endif
        .frame_done  (frame_done)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // Present one obstacle code with its checker mask for one cycle.
    task automatic send(input logic [63:0] m, input logic l);
        obs_valid    = 1'b1;
        obs_code     = CODE_W'($urandom);
        edge_mask_in = m;
        obs_last     = l;
        cycle();
        obs_valid    = 1'b0;
        obs_last     = 1'b0;
        edge_mask_in = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cycle();
        cycle();
        RST = 1'b0;
        cycle();
        n_checks++; if (obs_ready !== 1'b1) $display("FAIL reset_obs_ready got %b want 1", obs_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else n_pass++;
`ifdef PRM_BLOCKED_CNT_EN
        n_checks++; if (blocked_cnt !== 7'd0) $display("FAIL reset_blocked_cnt got %0d want 0", blocked_cnt); else n_pass++;
`endif
        obs_code = 15'h5A3C;
        #1;
        n_checks++; if (chk_code !== 15'h5A3C) $display("FAIL chk_code_copy got %h want 5a3c", chk_code); else n_pass++;
    endtask

    task automatic test_three_code();
        out_ready = 1'b1;
        send(64'h0000_0000_0000_0001, 1'b0);
        send(64'h8000_0000_0000_0000, 1'b0);
        send(64'h0000_0001_0000_0000, 1'b1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL tc_valid0 got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0000_0001) $display("FAIL tc_word0 got %h want 00000001", out_data); else n_pass++;
        n_checks++; if (out_idx !== 1'b0 || out_last !== 1'b0) $display("FAIL tc_idx0 got idx %b last %b want 0 0", out_idx, out_last); else n_pass++;
        n_checks++; if (obs_ready !== 1'b0) $display("FAIL tc_obs_ready_drain got %b want 0", obs_ready); else n_pass++;
`ifdef PRM_BLOCKED_CNT_EN
        n_checks++; if (blocked_cnt !== 7'd3) $display("FAIL tc_blocked_cnt got %0d want 3", blocked_cnt); else n_pass++;
`endif
        cycle();
        n_checks++; if (out_data !== 32'h8000_0001) $display("FAIL tc_word1 got %h want 80000001", out_data); else n_pass++;
        n_checks++; if (out_idx !== 1'b1 || out_last !== 1'b1) $display("FAIL tc_idx1 got idx %b last %b want 1 1", out_idx, out_last); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL tc_done_early got %b want 0", frame_done); else n_pass++;
        cycle();
        n_checks++; if (frame_done !== 1'b1 || out_valid !== 1'b0) $display("FAIL tc_done got done %b valid %b want 1 0", frame_done, out_valid); else n_pass++;
        cycle();
        n_checks++; if (frame_done !== 1'b0) $display("FAIL tc_done_pulse got %b want 0", frame_done); else n_pass++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send(64'hFFFF_FFFF_0000_0000, 1'b1);
        // Keep offering an all-ones code while stalled; it must not be taken.
        obs_valid    = 1'b1;
        edge_mask_in = '1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h0 || out_idx !== 1'b0 || obs_ready !== 1'b0)
                $display("FAIL stall_hold%0d got valid %b data %h idx %b ready %b want 1 00000000 0 0",
                         i, out_valid, out_data, out_idx, obs_ready);
            else n_pass++;
            cycle();
        end
        obs_valid    = 1'b0;
        edge_mask_in = '0;
        out_ready    = 1'b1;
        n_checks++; if (out_data !== 32'h0 || out_valid !== 1'b1) $display("FAIL stall_word0 got %h valid %b want 00000000 1", out_data, out_valid); else n_pass++;
`ifdef PRM_BLOCKED_CNT_EN
        n_checks++; if (blocked_cnt !== 7'd32) $display("FAIL stall_blocked_cnt got %0d want 32", blocked_cnt); else n_pass++;
`endif
        cycle();
        n_checks++; if (out_data !== 32'hFFFF_FFFF || out_last !== 1'b1) $display("FAIL stall_word1 got %h last %b want ffffffff 1", out_data, out_last); else n_pass++;
        cycle();
        n_checks++; if (frame_done !== 1'b1) $display("FAIL stall_done got %b want 1", frame_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        cycle();
        send('1, 1'b1);
        n_checks++; if (out_data !== 32'hFFFF_FFFF) $display("FAIL b2b_f1_word0 got %h want ffffffff", out_data); else n_pass++;
`ifdef PRM_BLOCKED_CNT_EN
        n_checks++; if (blocked_cnt !== 7'd64) $display("FAIL b2b_f1_cnt got %0d want 64", blocked_cnt); else n_pass++;
`endif
        cycle();
        n_checks++; if (out_data !== 32'hFFFF_FFFF || out_last !== 1'b1) $display("FAIL b2b_f1_word1 got %h last %b want ffffffff 1", out_data, out_last); else n_pass++;
        cycle();
        n_checks++; if (frame_done !== 1'b1 || obs_ready !== 1'b1) $display("FAIL b2b_gap got done %b ready %b want 1 1", frame_done, obs_ready); else n_pass++;
        send(64'h2, 1'b1);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h2) $display("FAIL b2b_f2_word0 got valid %b data %h want 1 00000002", out_valid, out_data); else n_pass++;
`ifdef PRM_BLOCKED_CNT_EN
        n_checks++; if (blocked_cnt !== 7'd1) $display("FAIL b2b_f2_cnt got %0d want 1", blocked_cnt); else n_pass++;
`endif
        cycle();
        n_checks++; if (out_data !== 32'h0 || out_idx !== 1'b1) $display("FAIL b2b_f2_word1 got %h idx %b want 00000000 1", out_data, out_idx); else n_pass++;
        cycle();
        n_checks++; if (frame_done !== 1'b1) $display("FAIL b2b_f2_done got %b want 1", frame_done); else n_pass++;
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        send(64'hFF, 1'b0);
        // Abort in ACCUM with a concurrent last code that must be discarded.
        frame_abort  = 1'b1;
        obs_valid    = 1'b1;
        obs_last     = 1'b1;
        edge_mask_in = '1;
        cycle();
        frame_abort  = 1'b0;
        obs_valid    = 1'b0;
        obs_last     = 1'b0;
        edge_mask_in = '0;
        n_checks++; if (out_valid !== 1'b0 || obs_ready !== 1'b1 || frame_done !== 1'b0)
            $display("FAIL abort_accum got valid %b ready %b done %b want 0 1 0", out_valid, obs_ready, frame_done); else n_pass++;
        send(64'h4, 1'b0);
        send(64'h0000_0010_0000_0000, 1'b1);
        n_checks++; if (out_data !== 32'h4) $display("FAIL abort_f2_word0 got %h want 00000004", out_data); else n_pass++;
        cycle();
        n_checks++; if (out_data !== 32'h10 || out_idx !== 1'b1) $display("FAIL abort_f2_word1 got %h idx %b want 00000010 1", out_data, out_idx); else n_pass++;
        // Abort in DRAIN, coinciding with the last word handshake.
        frame_abort = 1'b1;
        cycle();
        frame_abort = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) $display("FAIL abort_drain got valid %b done %b want 0 0", out_valid, frame_done); else n_pass++;
`ifdef PRM_BLOCKED_CNT_EN
        n_checks++; if (blocked_cnt !== 7'd0) $display("FAIL abort_cnt got %0d want 0", blocked_cnt); else n_pass++;
`endif
        cycle();
        n_checks++; if (frame_done !== 1'b0) $display("FAIL abort_no_done got %b want 0", frame_done); else n_pass++;
        send(64'h8, 1'b1);
        n_checks++; if (out_data !== 32'h8 || out_idx !== 1'b0) $display("FAIL abort_f3_word0 got %h idx %b want 00000008 0", out_data, out_idx); else n_pass++;
        cycle();
        n_checks++; if (out_data !== 32'h0 || out_last !== 1'b1) $display("FAIL abort_f3_word1 got %h last %b want 00000000 1", out_data, out_last); else n_pass++;
        cycle();
    endtask

    task automatic test_reset_in_drain();
        out_ready = 1'b0;
        send('1, 1'b1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rst_drain_pre got %b want 1", out_valid); else n_pass++;
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || obs_ready !== 1'b1 || frame_done !== 1'b0 || out_last !== 1'b0 || out_idx !== 1'b0)
            $display("FAIL rst_drain got valid %b ready %b done %b last %b idx %b want 0 1 0 0 0",
                     out_valid, obs_ready, frame_done, out_last, out_idx); else n_pass++;
`ifdef PRM_BLOCKED_CNT_EN
        n_checks++; if (blocked_cnt !== 7'd0) $display("FAIL rst_drain_cnt got %0d want 0", blocked_cnt); else n_pass++;
`endif
        out_ready = 1'b1;
        send(64'h3, 1'b1);
        n_checks++; if (out_data !== 32'h3) $display("FAIL rst_after_word0 got %h want 00000003", out_data); else n_pass++;
        cycle();
        cycle();
    endtask

    initial begin
        test_reset();
        test_three_code();
        test_stall();
        test_back_to_back();
        test_abort();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prm_edge_mask_accum.md
Name: prm_edge_mask_accum

Overview:
Collects the per-edge `edge_mask` outputs of the parallel PRM obstacle logic checkers (one checker per roadmap edge, all driven by the same 15-bit obstacle code A..O). It streams obstacle codes from upstream and sticky-ORs each resulting mask into a blocked-edge bitmap over one frame. At end of frame it drains the bitmap as fixed-width words to the roadmap/path-search stage.

Parameters:
NUM_EDGES, 1024, number of checker lanes (edges); must be a multiple of OUT_W
OUT_W, 32, width of a drained bitmap word
CODE_W, 15, obstacle code width (bit 0 = A ... bit 14 = O)

Ports:
CLK  in  1  clock; all logic on the rising edge
RST  in  1  synchronous, active-high reset
obs_valid  in  1  upstream obstacle code valid
obs_ready  out  1  block accepts an obstacle code
obs_code  in  CODE_W  obstacle code
obs_last  in  1  marks the final code of a frame
chk_code  out  CODE_W  code broadcast to the checker array; combinational copy of obs_code
edge_mask_in  in  NUM_EDGES  checker outputs for chk_code (combinational, same cycle)
frame_abort  in  1  discard the current frame
out_valid  out  1  bitmap word valid
out_ready  in  1  downstream accepts the word
out_data  out  OUT_W  bitmap word; bit i = edge k*OUT_W+i blocked
out_idx  out  clog2(NUM_EDGES/OUT_W)  word index k
out_last  out  1  high on the final word
frame_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- FSM states: IDLE, ACCUM, DRAIN.
- Reset values: state=IDLE, accum=0, word counter=0, out_valid=0, out_last=0, frame_done=0, obs_ready=1.
- obs_ready is 1 in IDLE and ACCUM, and 0 in DRAIN.
- An obstacle is accepted when obs_valid & obs_ready.
- IDLE, on accept:
  - accum <= edge_mask_in (load, not OR). This starts a new frame.
  - Go to ACCUM, or directly to DRAIN if obs_last=1.
- ACCUM, on accept:
  - accum <= accum | edge_mask_in.
  - If obs_last=1, go to DRAIN.
- The mask used at accept is the edge_mask_in present in the same cycle. Checkers are combinational; there is no pipeline stage.
- DRAIN:
  - out_valid=1 starting the cycle after the obs_last accept. Latency from last accept to first word is 1 cycle.
  - out_data = accum[k*OUT_W +: OUT_W] and out_idx = k. Word k starts at 0.
  - k increments on out_valid & out_ready.
  - out_last=1 when k = NUM_EDGES/OUT_W-1.
  - When the last word is accepted: go to IDLE, k <= 0, frame_done=1 for one cycle.
  - out_data, out_idx and out_last stay stable while out_valid & !out_ready.
- accum keeps its contents after drain until the next frame's first accept overwrites it.
- frame_abort, any state: next cycle state=IDLE, k=0, out_valid=0, accum=0, no frame_done. Any accept in the same cycle is discarded.
- frame_abort has priority over RST? No: RST has top priority; its effect is identical to abort plus all reset values.
- Single-code frame (obs_last on the first accept) is legal and drains that one mask.
- Back-to-back frames: the IDLE-cycle accept after frame_done is legal. Minimum gap is 0 cycles.

Optional Feature:
PRM_BLOCKED_CNT_EN.
- Defined:
  - Adds output blocked_cnt, width clog2(NUM_EDGES+1).
  - It equals the popcount of accum, registered when the state enters DRAIN.
  - It is valid throughout DRAIN and held until the next frame load. Reset value 0; cleared by abort.
  - Popcount may be computed combinationally on the final OR result.
- Undefined: the port and popcount logic are absent. All other behaviour is identical.

Test Plan:
- The bench uses NUM_EDGES=64 and OUT_W=32.
- Reset then idle: obs_ready=1, out_valid=0, frame_done=0, blocked_cnt=0.
- 3-code frame with masks 0x1, 0x8000_0000_0000_0000, 0x1_0000_0000, last on the 3rd, out_ready=1 → at cycle+1 word0=0x0000_0001 (idx0), then word1=0x8000_0001 (idx1, out_last=1), frame_done pulse; blocked_cnt=3.
- Single-code frame, mask 0xFFFF_FFFF_0000_0000, out_ready held 0 for 4 cycles → word0=0 held stable with out_valid=1; obs_ready=0 throughout; drains after out_ready rises.
- Two frames back-to-back, frame 1 all-ones and frame 2 mask 0x2 → frame 2 words are 0x2 and 0x0, proving load and no residue; blocked_cnt=64 then 1.
- frame_abort asserted mid-ACCUM and again mid-DRAIN after word0 → out_valid drops next cycle, no frame_done, next frame starts clean.
- RST asserted in DRAIN with out_valid=1 → next cycle all outputs at reset values, state IDLE.
